// File: rtl/key_debounce_multi.sv
// key_debounce_multi
//
// Multi-channel push-button front end. Every key pin is synchronised,
// sampled on a shared slow tick, and only accepted as a new level after
// STABLE_SAMPLES consecutive ticks disagree with the current debounced
// level. Each channel reports a clean level plus single-cycle press,
// release and long-press events.
//
// Ports:
//   clk            system clock
//   n_reset        asynchronous, active-low reset
//   key            raw asynchronous key pins (NUM_KEYS)
//   press          debounced level per key, 1 = pressed
//   press_pulse    one-cycle strobe when a press is accepted
//   release_pulse  one-cycle strobe when a release is accepted
//   long_pulse     one-cycle strobe when a hold reaches LONG_SAMPLES ticks
//   sample_tick    one-cycle strobe marking each sample instant
module key_debounce_multi #(
    parameter int NUM_KEYS       = 4,
    parameter int SAMPLE_DIV     = 20000,
    parameter int STABLE_SAMPLES = 3,
    parameter int LONG_SAMPLES   = 100,
    parameter bit ACTIVE_LOW     = 1'b1
) (
    input  logic                clk,
    input  logic                n_reset,
    input  logic [NUM_KEYS-1:0] key,
    output logic [NUM_KEYS-1:0] press,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse,
    output logic [NUM_KEYS-1:0] long_pulse,
    output logic                sample_tick
);

    localparam int DIV_W  = $clog2(SAMPLE_DIV);
    localparam int STAB_W = $clog2(STABLE_SAMPLES + 1);
    // A zero-length hold counter is not legal, so keep one bit when long-press is off.
    localparam int HOLD_W = (LONG_SAMPLES > 0) ? $clog2(LONG_SAMPLES + 1) : 1;

    localparam logic [DIV_W-1:0]    DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [STAB_W-1:0]   STAB_LAST = STAB_W'(STABLE_SAMPLES - 1);
    localparam logic [HOLD_W-1:0]   HOLD_MAX  = HOLD_W'(LONG_SAMPLES);
    localparam logic [NUM_KEYS-1:0] IDLE_LVL  = {NUM_KEYS{ACTIVE_LOW}};

    logic [NUM_KEYS-1:0] sync1_q, sync1_d;
    logic [NUM_KEYS-1:0] sync2_q, sync2_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [NUM_KEYS-1:0] press_q, press_d;
    logic [NUM_KEYS-1:0] press_pulse_q, press_pulse_d;
    logic [NUM_KEYS-1:0] release_pulse_q, release_pulse_d;
    logic [NUM_KEYS-1:0] long_pulse_q, long_pulse_d;
    logic [STAB_W-1:0]   stab_q [NUM_KEYS];
    logic [STAB_W-1:0]   stab_d [NUM_KEYS];
    logic [HOLD_W-1:0]   hold_q [NUM_KEYS];
    logic [HOLD_W-1:0]   hold_d [NUM_KEYS];

    logic                tick;
    logic [NUM_KEYS-1:0] sample;

    // Next-state logic: synchroniser, sample divider, and the per-key
    // stability filter and hold counter. Per-key state only moves on ticks.
    always_comb begin
        sync1_d         = key;
        sync2_d         = sync1_q;
        // Normalise polarity so 1 always means pressed from here on.
        sample          = sync2_q ^ IDLE_LVL;
        tick            = (div_q == DIV_LAST);
        div_d           = tick ? '0 : div_q + 1'b1;
        press_d         = press_q;
        press_pulse_d   = '0;
        release_pulse_d = '0;
        long_pulse_d    = '0;
        stab_d          = stab_q;
        hold_d          = hold_q;

        for (int i = 0; i < NUM_KEYS; i++) begin
            if (tick) begin
                // Any sample agreeing with the accepted level restarts the run.
                if (sample[i] == press_q[i]) begin
                    stab_d[i] = '0;
                end else if (stab_q[i] == STAB_LAST) begin
                    press_d[i] = ~press_q[i];
                    stab_d[i]  = '0;
                    if (press_q[i]) begin
                        release_pulse_d[i] = 1'b1;
                    end else begin
                        press_pulse_d[i] = 1'b1;
                    end
                end else begin
                    stab_d[i] = stab_q[i] + 1'b1;
                end
            end

            // The tick that raises press starts the hold at zero, so the
            // long pulse lands exactly LONG_SAMPLES ticks later. A releasing
            // tick also clears it and never fires a long pulse.
            if ((LONG_SAMPLES == 0) || !press_q[i] || !press_d[i]) begin
                hold_d[i] = '0;
            end else if (tick && (hold_q[i] < HOLD_MAX)) begin
                hold_d[i] = hold_q[i] + 1'b1;
                if (hold_q[i] == HOLD_MAX - 1'b1) begin
                    long_pulse_d[i] = 1'b1;
                end
            end
        end
    end

    // State registers. The synchroniser resets to the released pin level so
    // leaving reset never looks like a key edge.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sync1_q         <= IDLE_LVL;
            sync2_q         <= IDLE_LVL;
            div_q           <= '0;
            press_q         <= '0;
            press_pulse_q   <= '0;
            release_pulse_q <= '0;
            long_pulse_q    <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                stab_q[i] <= '0;
                hold_q[i] <= '0;
            end
        end else begin
            sync1_q         <= sync1_d;
            sync2_q         <= sync2_d;
            div_q           <= div_d;
            press_q         <= press_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
            long_pulse_q    <= long_pulse_d;
            stab_q          <= stab_d;
            hold_q          <= hold_d;
        end
    end

    assign press         = press_q;
    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;
    assign long_pulse    = long_pulse_q;
    assign sample_tick   = tick;

endmodule

// File: tb/tb_key_debounce_multi.sv
// tb_key_debounce_multi
//
// Directed bench for key_debounce_multi with two active-low keys, a
// 10-cycle sample divider, 3-sample stability filter and 5-tick long press.
module tb_key_debounce_multi;

    logic       clk = 1'b0;
    logic       n_reset;
    logic [1:0] key;
    logic [1:0] press;
    logic [1:0] press_pulse;
    logic [1:0] release_pulse;
    logic [1:0] long_pulse;
    logic       sample_tick;

    int checkCount = 0;
    int errorCount = 0;

    int cyc = 0;
    int pressCnt   [2] = '{0, 0};
    int releaseCnt [2] = '{0, 0};
    int longCnt    [2] = '{0, 0};
    int edgeCnt    [2] = '{0, 0};
    int pressCyc   [2] = '{0, 0};
    int longCyc    [2] = '{0, 0};
    int overlapCnt = 0;
    logic [1:0] prevPress = 2'b00;

    key_debounce_multi #(
        .NUM_KEYS(2),
        .SAMPLE_DIV(10),
        .STABLE_SAMPLES(3),
        .LONG_SAMPLES(5),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .n_reset(n_reset),
        .key(key),
        .press(press),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .long_pulse(long_pulse),
        .sample_tick(sample_tick)
    );

    // 10 time-unit clock
    always #5 clk = ~clk;

    // Cycle counter used to timestamp events seen by the monitor
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor, sampling on the falling edge away from updates
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (press_pulse[k]) begin
                pressCnt[k] = pressCnt[k] + 1;
                pressCyc[k] = cyc;
            end
            if (release_pulse[k]) releaseCnt[k] = releaseCnt[k] + 1;
            if (long_pulse[k]) begin
                longCnt[k] = longCnt[k] + 1;
                longCyc[k] = cyc;
            end
            if (press[k] != prevPress[k]) edgeCnt[k] = edgeCnt[k] + 1;
        end
        if (((press_pulse & release_pulse) != 2'b00) || ((long_pulse & press_pulse) != 2'b00))
            overlapCnt = overlapCnt + 1;
        prevPress = press;
    end

    // Single comparison point for every check in the bench
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic tickClk();
        @(posedge clk);
        #1;
    endtask

    // Drive the key pins and let the given number of cycles pass
    task automatic applyStimulus(input logic [1:0] keyVal, input int cycles);
        key = keyVal;
        repeat (cycles) tickClk();
    endtask

    // Wait, bounded, until press[k] reaches lvl; lat = cycles waited
    task automatic waitLevel(input int k, input logic lvl, input int maxCyc, output int lat);
        lat = 0;
        while ((press[k] !== lvl) && (lat < maxCyc)) begin
            tickClk();
            lat++;
        end
    endtask

    // Release reset with both keys down: quiet for 29 cycles, first tick at
    // cycle 9, and both presses accepted together on the third tick (cycle 30).
    task automatic releaseResetCheck(input string tag);
        int busy;
        int firstTick;
        busy = 0;
        firstTick = -1;
        @(posedge clk);
        #1 n_reset = 1'b1;
        for (int i = 1; i <= 29; i++) begin
            tickClk();
            if ((press | press_pulse | release_pulse | long_pulse) != 2'b00) busy++;
            if (sample_tick && (firstTick < 0)) firstTick = i;
        end
        checkOutput({tag, "_quiet"}, busy, 0);
        checkOutput({tag, "_first_tick"}, firstTick, 9);
        tickClk();
        checkOutput({tag, "_press_pulse_t3"}, int'(press_pulse), 3);
        checkOutput({tag, "_press_t3"}, int'(press), 3);
        checkOutput({tag, "_release_t3"}, int'(release_pulse), 0);
        tickClk();
        checkOutput({tag, "_pulse_width"}, int'(press_pulse), 0);
    endtask

    initial begin
        int lat;
        int p0, p1, r0, r1, l0, l1, e1;
        int seen;
        int guard;

        n_reset = 1'b0;
        key     = 2'b00;

        // Reset state with both pins held at the pressed level
        repeat (5) tickClk();
        checkOutput("reset_press", int'(press), 0);
        checkOutput("reset_pulses", int'({press_pulse, release_pulse, long_pulse}), 0);
        checkOutput("reset_tick", int'(sample_tick), 0);
        releaseResetCheck("rst1");

        // Clean press/release on key 0
        r0 = releaseCnt[0];
        r1 = releaseCnt[1];
        applyStimulus(2'b11, 100);
        checkOutput("release_both_level", int'(press), 0);
        checkOutput("release0_count", releaseCnt[0] - r0, 1);
        checkOutput("release1_count", releaseCnt[1] - r1, 1);

        p0 = pressCnt[0];
        key = 2'b10;
        waitLevel(0, 1'b1, 40, lat);
        checkOutput("clean_press_latency", int'((lat >= 23) && (lat <= 32)), 1);
        repeat (100 - lat) tickClk();
        checkOutput("clean_press_count", pressCnt[0] - p0, 1);
        r0 = releaseCnt[0];
        key = 2'b11;
        waitLevel(0, 1'b0, 40, lat);
        checkOutput("clean_release_latency", int'((lat >= 23) && (lat <= 32)), 1);
        repeat (40) tickClk();
        checkOutput("clean_release_count", releaseCnt[0] - r0, 1);

        // Bounce on key 1: toggles every 7 cycles never give 3 equal ticks
        p1 = pressCnt[1];
        r1 = releaseCnt[1];
        e1 = edgeCnt[1];
        for (int j = 0; j < 60; j++) begin
            key[1] = ((j / 7) % 2 == 0) ? 1'b0 : 1'b1;
            tickClk();
        end
        checkOutput("bounce_no_press", pressCnt[1] - p1, 0);
        checkOutput("bounce_no_release", releaseCnt[1] - r1, 0);
        checkOutput("bounce_no_edge", edgeCnt[1] - e1, 0);
        applyStimulus(2'b01, 60);
        checkOutput("bounce_settled_level", int'(press[1]), 1);
        checkOutput("bounce_one_press", pressCnt[1] - p1, 1);
        checkOutput("bounce_no_chatter", edgeCnt[1] - e1, 1);
        applyStimulus(2'b11, 60);

        // Short glitch on key 0: low for exactly two ticks
        p0 = pressCnt[0];
        r0 = releaseCnt[0];
        applyStimulus(2'b10, 20);
        applyStimulus(2'b11, 50);
        checkOutput("glitch_no_press", pressCnt[0] - p0, 0);
        checkOutput("glitch_no_release", releaseCnt[0] - r0, 0);
        checkOutput("glitch_level", int'(press[0]), 0);

        // Long press on key 0, then release and press again
        l0 = longCnt[0];
        applyStimulus(2'b10, 100);
        checkOutput("long_once", longCnt[0] - l0, 1);
        checkOutput("long_delay", longCyc[0] - pressCyc[0], 50);
        applyStimulus(2'b11, 60);
        l0 = longCnt[0];
        applyStimulus(2'b10, 100);
        checkOutput("long_again", longCnt[0] - l0, 1);
        checkOutput("long_again_delay", longCyc[0] - pressCyc[0], 50);
        applyStimulus(2'b11, 60);

        // Simultaneous press, then reset during the hold
        p0 = pressCnt[0];
        p1 = pressCnt[1];
        l0 = longCnt[0];
        l1 = longCnt[1];
        applyStimulus(2'b00, 40);
        checkOutput("simul_press0", pressCnt[0] - p0, 1);
        checkOutput("simul_press1", pressCnt[1] - p1, 1);
        checkOutput("simul_same_cycle", pressCyc[0] - pressCyc[1], 0);
        seen = 0;
        guard = 0;
        while ((seen < 3) && (guard < 50)) begin
            tickClk();
            guard++;
            if (sample_tick) seen++;
        end
        checkOutput("hold_ticks_seen", seen, 3);
        n_reset = 1'b0;
        #1;
        checkOutput("midhold_reset_press", int'(press), 0);
        checkOutput("midhold_reset_pulses", int'({press_pulse, release_pulse, long_pulse, sample_tick}), 0);
        repeat (10) tickClk();
        releaseResetCheck("rst2");
        checkOutput("midhold_no_long", (longCnt[0] - l0) + (longCnt[1] - l1), 0);
        repeat (60) tickClk();
        checkOutput("post_reset_long0", longCnt[0] - l0, 1);
        checkOutput("post_reset_long1", longCnt[1] - l1, 1);

        checkOutput("pulse_overlap", overlapCnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/key_debounce_multi.md
# key_debounce_multi

Parametrised multi-channel push-button front end: synchronises NUM_KEYS raw mechanical key inputs, debounces each on a shared slow sample tick with a consecutive-sample stability filter, and produces a clean per-key pressed level plus single-cycle press, release and long-press event pulses. It sits between board button pins and control logic (mode FSMs, counters, LED/display controllers) and supersedes the single-key fixed-20 000-cycle sampler.

## Interface
- NUM_KEYS, 4, number of independent key channels (>=1)
- SAMPLE_DIV, 20000, clk cycles per sample tick (>=2)
- STABLE_SAMPLES, 3, consecutive differing samples required to accept a new key state (>=1)
- LONG_SAMPLES, 100, ticks a key must stay pressed to fire long_pulse (0 disables long-press)
- ACTIVE_LOW, 1, 1: pin low = pressed; 0: pin high = pressed
- clk  in  1  system clock
- n_reset  in  1  asynchronous, active-low reset
- key  in  NUM_KEYS  raw asynchronous key pins
- press  out  NUM_KEYS  debounced level, 1 = pressed
- press_pulse  out  NUM_KEYS  1-clk pulse on accepted press
- release_pulse  out  NUM_KEYS  1-clk pulse on accepted release
- long_pulse  out  NUM_KEYS  1-clk pulse when hold reaches LONG_SAMPLES ticks
- sample_tick  out  1  1-clk strobe marking each sample instant (debug/reuse)

## Operation
- Synchroniser: 2-flop per key; reset value = released level (1 if ACTIVE_LOW else 0). Normalised sample s[i] = sync[i] XOR ACTIVE_LOW (1 = pressed).
- Divider: counter 0..SAMPLE_DIV-1, width $clog2(SAMPLE_DIV); wraps to 0 after SAMPLE_DIV-1. sample_tick = 1 during the cycle count == SAMPLE_DIV-1; all per-key updates occur on that clk edge only.
- Per-key stability counter (width $clog2(STABLE_SAMPLES+1)), on each tick:
  - s[i] == press[i]: counter <= 0.
  - s[i] != press[i] and counter == STABLE_SAMPLES-1: press[i] toggles, counter <= 0, press_pulse[i] or release_pulse[i] asserted for that one cycle.
  - otherwise: counter increments.
- Per-key hold counter (width $clog2(LONG_SAMPLES+1)), saturating:
  - Cleared to 0 whenever press[i] is 0 and on the tick where press[i] rises.
  - On each later tick with press[i] = 1: increments if < LONG_SAMPLES; when it becomes LONG_SAMPLES, long_pulse[i] asserted one cycle. Saturates; no repeat until released and pressed again.
  - LONG_SAMPLES = 0: long_pulse held 0, counter unused.
- Channels fully independent; simultaneous events on several keys all reported in the same cycle.
- press_pulse and release_pulse of the same key never coincide; long_pulse never coincides with press_pulse.

## Timing
- Reset (async assert, sync-to-clk release by board): press, all pulses, sample_tick = 0; divider, stability and hold counters = 0. No pulse may fire on the first cycles after reset deassert merely because of reset.
- Reset mid-bounce or mid-hold discards all progress; a key held through reset is re-accepted as a fresh press after STABLE_SAMPLES ticks.
- Pin-to-sync latency 2 clk. Accept latency after pin settles: STABLE_SAMPLES ticks, i.e. between (STABLE_SAMPLES-1)*SAMPLE_DIV+1 and STABLE_SAMPLES*SAMPLE_DIV clk, plus 2.
- Pulses and press update on the same clk edge (registered outputs, no combinational path from key).
- Any glitch seen on fewer than STABLE_SAMPLES consecutive ticks is rejected; activity between ticks is invisible.
- long_pulse fires exactly LONG_SAMPLES ticks after the tick that raised press.

## Test plan
Bench parameters: NUM_KEYS=2, SAMPLE_DIV=10, STABLE_SAMPLES=3, LONG_SAMPLES=5, ACTIVE_LOW=1.
- Reset: hold n_reset=0 with key=2'b00 -> all outputs 0; release -> no pulse for the first 20 clk; press[0] rises on the 3rd tick (~30 clk), with press_pulse[0]=1 for exactly 1 cycle.
- Clean press/release on key[0]: drive 0 for 100 clk, then 1 -> press[0]=1 within 32 clk of the fall with one press_pulse; press[0]=0 within 32 clk of the rise with one release_pulse.
- Bounce: toggle key[1] every 7 clk for 60 clk, then hold low -> no pulses during the bounce; exactly one press_pulse[1] after settling; press[1] never chatters.
- Short glitch: key[0] low for exactly 2 ticks (20 clk) -> no press, no pulses; stability counter returns to 0.
- Long press: hold key[0] low -> long_pulse[0] exactly 5 ticks (50 clk) after press_pulse[0]; no second long_pulse while held; release then re-press -> long_pulse fires again.
- Simultaneous plus reset mid-hold: press both keys together -> both press_pulses in the same cycle; assert n_reset at tick 3 of the hold -> outputs 0 immediately, no long_pulse; after release of reset with keys still down -> fresh press_pulses after 3 ticks.
